roll_recorder: RTL and testbench
================================

Name: roll_recorder

Overview:
Sits at the receiving end of the 4-bit random-number bus that drives the display, the o_random_out output of the die-roll generator.
- The bus has no valid strobe, so this block infers end-of-roll: the bus value must stay stable for SETTLE_CYC cycles after a change.
- The settled result is written into a small circular history.
- The user browses past results with debounced prev/next key pulses; the selected entry drives a second display.

Parameters:
DATA_W, 4, width of monitored bus and stored entries
DEPTH, 8, history entries; power of two, at least 2
SETTLE_CYC, 25_000_000, consecutive stable cycles that declare a roll finished (0.5 s at 50 MHz); at least 2

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  reset, synchronous, active-low
i_data  input  DATA_W  monitored random-number bus
i_prev  input  1  one-cycle pulse: step to an older entry
i_next  input  1  one-cycle pulse: step to a newer entry
i_clear  input  1  one-cycle pulse: empty the history
o_view  output  DATA_W  selected history entry; 0 when empty
o_index  output  $clog2(DEPTH)  browse offset, 0 = newest
o_count  output  $clog2(DEPTH)+1  valid entries, saturates at DEPTH
o_new  output  1  one-cycle pulse, the cycle after a capture
o_browsing  output  1  high when o_index != 0

Behaviour:
- One clock; reset is synchronous and active-low (i_clk, i_rst_n). Sampled only at the rising edge of i_clk.
- Reset values: all outputs 0; last_r=0, stable_cnt=0, wr_ptr=0, state S_IDLE; memory contents don't-care.
- Capture FSM, states S_IDLE and S_TRACK:
  - Any state, i_data != last_r: last_r<=i_data, stable_cnt<=0, go to S_TRACK.
  - S_IDLE, i_data == last_r: stay; nothing changes.
  - S_TRACK, i_data == last_r: stable_cnt++.
  - S_TRACK, stable_cnt == SETTLE_CYC-1 (SETTLE_CYC stable cycles): write last_r to mem[wr_ptr]; wr_ptr<=wr_ptr+1 (mod DEPTH, wraps); count<=min(count+1, DEPTH); offset<=0; o_new<=1 for exactly one cycle; go to S_IDLE.
  - A roll ending on the same value as the pre-roll bus is still captured, provided the bus changed at least once in between.
- Browse offset:
  - i_prev: offset<=offset+1, saturating at count-1 (stays 0 if count is 0).
  - i_next: offset<=offset-1, saturating at 0.
  - i_prev and i_next together: ignored.
- Read path:
  - o_view = mem[(wr_ptr-1-offset) mod DEPTH] when count>0, else 0.
  - Combinational from registers, so it is visible the cycle after the triggering edge.
- Priority, highest first:
  1. Reset.
  2. i_clear: count=0, wr_ptr=0, offset=0, state S_IDLE, last_r<=i_data, o_new=0.
  3. Capture: offset forced to 0; a same-cycle i_prev/i_next is dropped.
  4. Browse.
- Wrap-around: after more than DEPTH captures, the oldest entry is overwritten and count stays at DEPTH.
- Reset asserted mid-roll or mid-browse: everything returns to reset values on the next edge; a partial roll is discarded.

Optional Feature:
ROLL_RECORDER_STATS_EN
- Defined: adds ports o_max (DATA_W) and o_hist_full (1).
  - o_max is the largest value captured since reset or clear; it is 0 when empty and updated in the same cycle the entry is written.
  - o_hist_full = (count == DEPTH).
- Undefined: both ports and their logic are absent; the rest of the behaviour is identical.

Decomposition:
- roll_recorder_pkg holds the capture-state enum (S_IDLE, S_TRACK) and the default constants DATA_W_DEF=4 and DEPTH_DEF=8.
- One sub-module, history_ram: DEPTH x DATA_W register file with one synchronous write port and one combinational read port. It is reset-free; validity is tracked by count.

Test Plan:
All scenarios use SETTLE_CYC=4, DEPTH=4.
1. Reset with i_data=0 held -> all outputs 0; no o_new for 20 cycles.
2. i_data 3,7,5, then 5 held 4 cycles -> single o_new pulse; o_count=1; o_view=5; o_index=0.
3. 5 held 3 cycles, then 9 held 4 cycles -> no capture at 5; one capture of 9; o_count=1.
4. Captures 1,2,3,4,5 -> o_count=4; o_view=5. Then i_prev x4 -> o_view 4,3,2,2; o_index 1,2,3,3 (entry 1 overwritten). Then i_next x1 -> o_view=3.
5. o_index=2, then a capture of 8 in the same cycle as an i_prev pulse -> o_index=0; o_view=8; o_browsing=0.
6. i_clear during S_TRACK (bus stable 2 cycles) -> o_count=0; o_view=0; bus held 10 more cycles -> no o_new. With STATS_EN: o_max=0.

Source files
------------

// File: rtl/roll_recorder_pkg.sv
// Shared types and default sizing for the roll recorder.
package roll_recorder_pkg;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_TRACK = 1'b1
    } cap_state_e;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_DEF  = 8;

endpackage

// File: rtl/roll_recorder_history_ram.sv
// Reset-free DEPTH x DATA_W register file: one synchronous write port and one combinational read port.
module history_ram
    import roll_recorder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Entry validity is tracked by the owner's count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/roll_recorder.sv
// Infers end-of-roll on an unstrobed random-number bus, keeps a circular history and lets the user browse it.
// Optional statistics outputs (o_max, o_hist_full) are enabled by defining ROLL_RECORDER_STATS_EN.
module roll_recorder
    import roll_recorder_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int SETTLE_CYC = 25_000_000
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_prev,
    input  logic                     i_next,
    input  logic                     i_clear,
    output logic [DATA_W-1:0]        o_view,
    output logic [$clog2(DEPTH)-1:0] o_index,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_new,
    output logic                     o_browsing
`ifdef ROLL_RECORDER_STATS_EN
    ,
    output logic [DATA_W-1:0]        o_max,
    output logic                     o_hist_full
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(SETTLE_CYC);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] DEPTH_CNT   = CW'(DEPTH);

    cap_state_e        state_r;
    logic [DATA_W-1:0] last_r;
    logic [SW-1:0]     stable_cnt_r;
    logic [AW-1:0]     wr_ptr_r;
    logic [CW-1:0]     count_r;
    logic [AW-1:0]     offset_r;
    logic              new_r;
`ifdef ROLL_RECORDER_STATS_EN
    logic [DATA_W-1:0] max_r;
`endif

    logic              capture_s;
    logic              we_s;
    logic              step_older_s;
    logic              step_newer_s;
    logic [AW-1:0]     rd_addr_s;
    logic [DATA_W-1:0] rd_data_s;

    // Capture and browse decisions derived from current state.
    always_comb begin
        capture_s    = 1'b0;
        step_older_s = 1'b0;
        step_newer_s = 1'b0;
        if ((state_r == S_TRACK) && (i_data == last_r) && (stable_cnt_r == SETTLE_LAST)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        if (i_prev && !i_next && (count_r != '0) && ({1'b0, offset_r} < (count_r - CW'(1)))) begin
            step_older_s = 1'b1;
        end else begin
            step_older_s = 1'b0;
        end
        if (i_next && !i_prev && (offset_r != '0)) begin
            step_newer_s = 1'b1;
        end else begin
            step_newer_s = 1'b0;
        end
    end

    assign we_s      = capture_s & i_rst_n & ~i_clear;
    assign rd_addr_s = wr_ptr_r - AW'(1) - offset_r;

    history_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_history_ram (
        .clk   (i_clk),
        .we    (we_s),
        .waddr (wr_ptr_r),
        .wdata (last_r),
        .raddr (rd_addr_s),
        .rdata (rd_data_s)
    );

    // Capture FSM, history pointers and browse offset; clear outranks capture, capture outranks browse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r      <= S_IDLE;
            last_r       <= '0;
            stable_cnt_r <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            offset_r     <= '0;
            new_r        <= 1'b0;
`ifdef ROLL_RECORDER_STATS_EN
            max_r        <= '0;
`endif
        end else if (i_clear) begin
            state_r      <= S_IDLE;
            last_r       <= i_data;
            stable_cnt_r <= '0;
            wr_ptr_r     <= '0;
            count_r      <= '0;
            offset_r     <= '0;
            new_r        <= 1'b0;
`ifdef ROLL_RECORDER_STATS_EN
            max_r        <= '0;
`endif
        end else begin
            new_r <= capture_s;
            case (state_r)
                S_IDLE: begin
                    if (i_data != last_r) begin
                        last_r       <= i_data;
                        stable_cnt_r <= '0;
                        state_r      <= S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (i_data != last_r) begin
                        last_r       <= i_data;
                        stable_cnt_r <= '0;
                    end else if (stable_cnt_r == SETTLE_LAST) begin
                        stable_cnt_r <= '0;
                        state_r      <= S_IDLE;
                    end else begin
                        stable_cnt_r <= stable_cnt_r + SW'(1);
                    end
                end
                default: begin
                    stable_cnt_r <= '0;
                    state_r      <= S_IDLE;
                end
            endcase

            if (capture_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
                offset_r <= '0;
                if (count_r != DEPTH_CNT) begin
                    count_r <= count_r + CW'(1);
                end
`ifdef ROLL_RECORDER_STATS_EN
                if (last_r > max_r) begin
                    max_r <= last_r;
                end
`endif
            end else if (step_older_s) begin
                offset_r <= offset_r + AW'(1);
            end else if (step_newer_s) begin
                offset_r <= offset_r - AW'(1);
            end
        end
    end

    // Empty history shows zero rather than stale memory contents.
    always_comb begin
        o_view = '0;
        if (count_r != '0) begin
            o_view = rd_data_s;
        end else begin
            o_view = '0;
        end
    end

    assign o_index    = offset_r;
    assign o_count    = count_r;
    assign o_new      = new_r;
    assign o_browsing = (offset_r != '0);
`ifdef ROLL_RECORDER_STATS_EN
    assign o_max       = max_r;
    assign o_hist_full = (count_r == DEPTH_CNT);
`endif

endmodule

// File: tb/tb_roll_recorder.sv
// Directed self-checking bench for roll_recorder with SETTLE_CYC=4, DEPTH=4; inputs driven and outputs sampled on the falling edge.
module tb_roll_recorder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] data;
    logic       prev;
    logic       next;
    logic       clear;
    logic [3:0] view;
    logic [1:0] index;
    logic [2:0] count;
    logic       new_p;
    logic       browsing;
`ifdef ROLL_RECORDER_STATS_EN
    logic [3:0] max_v;
    logic       hist_full;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int new_cnt  = 0;
    int base;

    roll_recorder #(
        .DATA_W     (4),
        .DEPTH      (4),
        .SETTLE_CYC (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_data     (data),
        .i_prev     (prev),
        .i_next     (next),
        .i_clear    (clear),
        .o_view     (view),
        .o_index    (index),
        .o_count    (count),
        .o_new      (new_p),
        .o_browsing (browsing)
`ifdef ROLL_RECORDER_STATS_EN
        ,
        .o_max      (max_v),
        .o_hist_full(hist_full)
`endif
    );

    always #5 clk = ~clk;

    // Counts o_new pulses, each seen once at the rising edge after it appears.
    always @(posedge clk) begin
        if (new_p === 1'b1) begin
            new_cnt <= new_cnt + 1;
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_prev();
        prev = 1'b1;
        cyc(1);
        prev = 1'b0;
    endtask

    task automatic pulse_next();
        next = 1'b1;
        cyc(1);
        next = 1'b0;
    endtask

    // A new value on the bus: change edge plus four stable edges ends in a capture.
    task automatic roll(input logic [3:0] v);
        data = v;
        cyc(4);
        chk("roll_pre_new", 32'(new_p), 32'd0);
        cyc(1);
        chk("roll_new", 32'(new_p), 32'd1);
        chk("roll_view", 32'(view), 32'(v));
        chk("roll_index", 32'(index), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        data  = 4'd0;
        prev  = 1'b0;
        next  = 1'b0;
        clear = 1'b0;
        cyc(2);

        // Reset state
        chk("rst_view", 32'(view), 32'd0);
        chk("rst_index", 32'(index), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_new", 32'(new_p), 32'd0);
        chk("rst_browsing", 32'(browsing), 32'd0);
`ifdef ROLL_RECORDER_STATS_EN
        chk("rst_max", 32'(max_v), 32'd0);
        chk("rst_full", 32'(hist_full), 32'd0);
`endif
        rst_n = 1'b1;
        base = new_cnt;
        cyc(20);
        chk("idle_no_new", 32'(new_cnt - base), 32'd0);
        chk("idle_count", 32'(count), 32'd0);

        // Scenario 2: 3,7,5 then 5 held
        base = new_cnt;
        data = 4'd3; cyc(1);
        data = 4'd7; cyc(1);
        data = 4'd5; cyc(1);
        cyc(3);
        chk("s2_not_yet", 32'(count), 32'd0);
        cyc(1);
        chk("s2_new", 32'(new_p), 32'd1);
        chk("s2_count", 32'(count), 32'd1);
        chk("s2_view", 32'(view), 32'd5);
        chk("s2_index", 32'(index), 32'd0);
        cyc(1);
        chk("s2_new_drop", 32'(new_p), 32'd0);
        cyc(5);
        chk("s2_single_pulse", 32'(new_cnt - base), 32'd1);

        // Scenario 3: clear, partial roll on 5, full roll on 9
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("s3_clear_count", 32'(count), 32'd0);
        chk("s3_clear_view", 32'(view), 32'd0);
        base = new_cnt;
        data = 4'd6; cyc(1);
        data = 4'd5; cyc(3);
        data = 4'd9; cyc(1);
        chk("s3_no_cap5", 32'(new_cnt - base), 32'd0);
        cyc(3);
        chk("s3_count_pre", 32'(count), 32'd0);
        cyc(1);
        chk("s3_new", 32'(new_p), 32'd1);
        chk("s3_count", 32'(count), 32'd1);
        chk("s3_view", 32'(view), 32'd9);
        cyc(1);
        chk("s3_single", 32'(new_cnt - base), 32'd1);

        // Scenario 4: wrap-around and browsing
        roll(4'd1);
        roll(4'd2);
        roll(4'd3);
        roll(4'd4);
        roll(4'd5);
        chk("s4_count_sat", 32'(count), 32'd4);
        chk("s4_view", 32'(view), 32'd5);
        pulse_prev();
        chk("s4_p1_view", 32'(view), 32'd4);
        chk("s4_p1_index", 32'(index), 32'd1);
        chk("s4_p1_browsing", 32'(browsing), 32'd1);
        pulse_prev();
        chk("s4_p2_view", 32'(view), 32'd3);
        chk("s4_p2_index", 32'(index), 32'd2);
        pulse_prev();
        chk("s4_p3_view", 32'(view), 32'd2);
        chk("s4_p3_index", 32'(index), 32'd3);
        pulse_prev();
        chk("s4_p4_view", 32'(view), 32'd2);
        chk("s4_p4_index", 32'(index), 32'd3);
        pulse_next();
        chk("s4_n1_view", 32'(view), 32'd3);
        chk("s4_n1_index", 32'(index), 32'd2);
        prev = 1'b1; next = 1'b1; cyc(1); prev = 1'b0; next = 1'b0;
        chk("s4_both_index", 32'(index), 32'd2);
        chk("s4_both_view", 32'(view), 32'd3);

        // Scenario 5: capture of 8 coincides with prev pulse
        data = 4'd8; cyc(4);
        chk("s5_pre_index", 32'(index), 32'd2);
        prev = 1'b1; cyc(1); prev = 1'b0;
        chk("s5_new", 32'(new_p), 32'd1);
        chk("s5_index", 32'(index), 32'd0);
        chk("s5_view", 32'(view), 32'd8);
        chk("s5_browsing", 32'(browsing), 32'd0);
        chk("s5_count", 32'(count), 32'd4);
`ifdef ROLL_RECORDER_STATS_EN
        chk("s5_max", 32'(max_v), 32'd9);
        chk("s5_full", 32'(hist_full), 32'd1);
`endif
        pulse_prev();
        chk("s5_older_view", 32'(view), 32'd5);

        // Scenario 6: clear while tracking
        data = 4'd6; cyc(3);
        clear = 1'b1; cyc(1); clear = 1'b0;
        chk("s6_count", 32'(count), 32'd0);
        chk("s6_view", 32'(view), 32'd0);
        chk("s6_index", 32'(index), 32'd0);
`ifdef ROLL_RECORDER_STATS_EN
        chk("s6_max", 32'(max_v), 32'd0);
        chk("s6_full", 32'(hist_full), 32'd0);
`endif
        base = new_cnt;
        cyc(10);
        chk("s6_no_new", 32'(new_cnt - base), 32'd0);

        // Roll returning to the pre-roll value is still captured
        data = 4'd2; cyc(1);
        roll(4'd6);
        chk("same_val_count", 32'(count), 32'd1);

        // Reset mid-roll discards the partial roll
        data = 4'd3; cyc(2);
        data = 4'd0; rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_view", 32'(view), 32'd0);
        base = new_cnt;
        cyc(10);
        chk("mid_rst_no_new", 32'(new_cnt - base), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
